// File: rtl/usb_rx_packet_buffer.sv
// -----------------------------------------------------------------------------
// usb_rx_packet_buffer
//
// Receive-side packet buffer that sits behind the USB RX control unit. Incoming
// bytes are written speculatively into a circular buffer; a packet becomes
// visible to the reader only when reception ends cleanly. Packets that see an
// error or overflow the buffer are rewound so the reader never sees them.
//
// Optional feature macro: USB_RX_PID_STRIP_EN
//   When defined, the first accepted byte of each packet is captured as the
//   PID (reported on rx_pid at commit) instead of being stored and counted.
//
// Ports
//   clk        : system clock, rising edge
//   rst        : asynchronous active-high reset
//   rcving     : packet in progress
//   w_enable   : byte-valid strobe for rcv_data
//   rcv_data   : received byte
//   r_error    : receive error
//   rd_en      : pop one committed byte
//   rd_data    : committed byte at head (fall-through), 8'h00 when empty
//   buf_empty  : no committed bytes
//   buf_full   : speculative occupancy equals DEPTH
//   byte_count : committed bytes available to the reader
//   pkt_ready  : one-cycle pulse, good packet committed
//   pkt_len    : data-byte length of the last committed packet
//   pkt_drop   : one-cycle pulse, packet discarded
//   rx_pid     : PID of the last committed packet (8'h00 without the macro)
// -----------------------------------------------------------------------------
module usb_rx_packet_buffer #(
    parameter int DEPTH = 64,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          rcving,
    input  logic          w_enable,
    input  logic [7:0]    rcv_data,
    input  logic          r_error,
    input  logic          rd_en,
    output logic [7:0]    rd_data,
    output logic          buf_empty,
    output logic          buf_full,
    output logic [AW:0]   byte_count,
    output logic          pkt_ready,
    output logic [AW:0]   pkt_len,
    output logic          pkt_drop,
    output logic [7:0]    rx_pid
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_BAD    = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] cmt_ptr_q, cmt_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0] len_cnt_q, len_cnt_d;
    logic        pkt_ready_q, pkt_ready_d;
    logic        pkt_drop_q, pkt_drop_d;
    logic [AW:0] pkt_len_q, pkt_len_d;
    logic [7:0]  rx_pid_q, rx_pid_d;
    logic [7:0]  mem_q [DEPTH];

    logic [AW:0] occ_s;
    logic        full_s;
    logic        empty_s;
    logic        in_pkt_s;
    logic        wr_acc_s;
    logic        overflow_s;
    logic        mem_we_s;
    logic        pop_s;
    logic        has_payload_s;
    logic [7:0]  pid_commit_s;

    assign occ_s      = wr_ptr_q - rd_ptr_q;
    assign full_s     = (occ_s == (AW+1)'(DEPTH));
    assign byte_count = cmt_ptr_q - rd_ptr_q;
    assign empty_s    = (byte_count == {(AW+1){1'b0}});
    // A packet is being received either in ACTIVE or on the IDLE cycle where rcving rises.
    assign in_pkt_s   = (state_q == ST_ACTIVE) || ((state_q == ST_IDLE) && rcving);
    assign wr_acc_s   = in_pkt_s && w_enable && !r_error && !full_s;
    // Full is judged on pre-edge pointers, so a concurrent pop does not rescue a write.
    assign overflow_s = in_pkt_s && w_enable && full_s;
    assign pop_s      = rd_en && !empty_s;

`ifdef USB_RX_PID_STRIP_EN
    logic       pid_seen_q, pid_seen_d;
    logic [7:0] pid_pend_q, pid_pend_d;
    logic       pid_byte_s;

    // The pending-PID flag from a previous packet is stale once we are back in IDLE.
    assign pid_byte_s    = wr_acc_s && !((state_q == ST_ACTIVE) && pid_seen_q);
    assign pid_seen_d    = ((state_q == ST_ACTIVE) && pid_seen_q) || pid_byte_s;
    assign pid_pend_d    = pid_byte_s ? rcv_data : pid_pend_q;
    assign mem_we_s      = wr_acc_s && !pid_byte_s;
    assign has_payload_s = (len_cnt_d != {(AW+1){1'b0}}) || pid_seen_d;
    assign pid_commit_s  = pid_pend_d;

    // Pending PID capture.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pid_seen_q <= 1'b0;
            pid_pend_q <= 8'h00;
        end else begin
            pid_seen_q <= pid_seen_d;
            pid_pend_q <= pid_pend_d;
        end
    end
`else
    assign mem_we_s      = wr_acc_s;
    assign has_payload_s = (len_cnt_d != {(AW+1){1'b0}});
    assign pid_commit_s  = 8'h00;
`endif

    // Next-state, pointer and pulse logic.
    always_comb begin
        state_d     = state_q;
        cmt_ptr_d   = cmt_ptr_q;
        pkt_ready_d = 1'b0;
        pkt_drop_d  = 1'b0;
        pkt_len_d   = pkt_len_q;
        rx_pid_d    = rx_pid_q;
        rd_ptr_d    = rd_ptr_q + (AW+1)'(pop_s);
        wr_ptr_d    = wr_ptr_q + (AW+1)'(mem_we_s);
        // Length restarts with each new packet.
        if (state_q == ST_IDLE) begin
            len_cnt_d = (AW+1)'(mem_we_s);
        end else begin
            len_cnt_d = len_cnt_q + (AW+1)'(mem_we_s);
        end
        case (state_q)
            ST_IDLE: begin
                if (rcving) begin
                    if (r_error || overflow_s) begin
                        state_d = ST_BAD;
                    end else begin
                        state_d = ST_ACTIVE;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ACTIVE: begin
                if (r_error || overflow_s) begin
                    state_d = ST_BAD;
                end else if (!rcving) begin
                    state_d = ST_IDLE;
                    if (has_payload_s) begin
                        cmt_ptr_d   = wr_ptr_d;
                        pkt_len_d   = len_cnt_d;
                        pkt_ready_d = 1'b1;
                        rx_pid_d    = pid_commit_s;
                    end else begin
                        pkt_ready_d = 1'b0;
                    end
                end else begin
                    state_d = ST_ACTIVE;
                end
            end
            ST_BAD: begin
                if (!rcving) begin
                    state_d    = ST_IDLE;
                    wr_ptr_d   = cmt_ptr_q;
                    pkt_drop_d = 1'b1;
                end else begin
                    state_d = ST_BAD;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and pointer registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            wr_ptr_q    <= {(AW+1){1'b0}};
            cmt_ptr_q   <= {(AW+1){1'b0}};
            rd_ptr_q    <= {(AW+1){1'b0}};
            len_cnt_q   <= {(AW+1){1'b0}};
            pkt_ready_q <= 1'b0;
            pkt_drop_q  <= 1'b0;
            pkt_len_q   <= {(AW+1){1'b0}};
            rx_pid_q    <= 8'h00;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            cmt_ptr_q   <= cmt_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            len_cnt_q   <= len_cnt_d;
            pkt_ready_q <= pkt_ready_d;
            pkt_drop_q  <= pkt_drop_d;
            pkt_len_q   <= pkt_len_d;
            rx_pid_q    <= rx_pid_d;
        end
    end

    // Byte storage; contents are only meaningful between rd_ptr and wr_ptr.
    always_ff @(posedge clk) begin
        if (mem_we_s) begin
            mem_q[wr_ptr_q[AW-1:0]] <= rcv_data;
        end
    end

    assign rd_data   = empty_s ? 8'h00 : mem_q[rd_ptr_q[AW-1:0]];
    assign buf_empty = empty_s;
    assign buf_full  = full_s;
    assign pkt_ready = pkt_ready_q;
    assign pkt_drop  = pkt_drop_q;
    assign pkt_len   = pkt_len_q;
    assign rx_pid    = rx_pid_q;

endmodule

// File: tb/tb_usb_rx_packet_buffer.sv
module tb_usb_rx_packet_buffer;

    localparam int DEPTH = 64;
    localparam int AW    = 6;
`ifdef USB_RX_PID_STRIP_EN
    localparam bit STRIP = 1'b1;
`else
    localparam bit STRIP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rcving = 1'b0;
    logic        w_enable = 1'b0;
    logic [7:0]  rcv_data = 8'h00;
    logic        r_error = 1'b0;
    logic        rd_en = 1'b0;
    logic [7:0]  rd_data;
    logic        buf_empty;
    logic        buf_full;
    logic [AW:0] byte_count;
    logic        pkt_ready;
    logic [AW:0] pkt_len;
    logic        pkt_drop;
    logic [7:0]  rx_pid;

    usb_rx_packet_buffer #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .rcving(rcving), .w_enable(w_enable),
        .rcv_data(rcv_data), .r_error(r_error), .rd_en(rd_en),
        .rd_data(rd_data), .buf_empty(buf_empty), .buf_full(buf_full),
        .byte_count(byte_count), .pkt_ready(pkt_ready), .pkt_len(pkt_len),
        .pkt_drop(pkt_drop), .rx_pid(rx_pid)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int drop_seen = 0;

    // Behavioural model: committed bytes, bytes of the packet in flight, and a mode.
    byte unsigned cq[$];
    byte unsigned pk[$];
    int          m_mode = 0;       // 0 waiting, 1 receiving, 2 discarding
    bit          m_pid_have = 1'b0;
    int          m_pid_pend = 0;
    int          m_rx_pid = 0;
    int          m_pkt_len = 0;
    bit          m_ready = 1'b0;
    bit          m_drop = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic model_edge();
        int  occ;
        bit  full;
        bit  wacc;
        if (rst) begin
            cq.delete(); pk.delete();
            m_mode = 0; m_pid_have = 0; m_pid_pend = 0;
            m_rx_pid = 0; m_pkt_len = 0; m_ready = 0; m_drop = 0;
            return;
        end
        occ = cq.size() + pk.size();
        full = (occ == DEPTH);
        m_ready = 0;
        m_drop  = 0;
        if (rd_en && cq.size() > 0) void'(cq.pop_front());
        if (m_mode == 0 && rcving) begin
            m_mode = 1; pk.delete(); m_pid_have = 0;
        end
        if (m_mode == 1) begin
            wacc = w_enable && !r_error && !full;
            if (r_error || (w_enable && full)) begin
                m_mode = 2;
            end else begin
                if (wacc) begin
                    if (STRIP && !m_pid_have) begin
                        m_pid_have = 1; m_pid_pend = int'(rcv_data);
                    end else begin
                        pk.push_back(rcv_data);
                    end
                end
                if (!rcving) begin
                    m_mode = 0;
                    if (pk.size() > 0 || m_pid_have) begin
                        m_pkt_len = pk.size();
                        foreach (pk[i]) cq.push_back(pk[i]);
                        pk.delete();
                        m_ready = 1;
                        m_rx_pid = STRIP ? m_pid_pend : 0;
                    end
                end
            end
        end else if (m_mode == 2) begin
            if (!rcving) begin
                m_mode = 0; m_drop = 1; pk.delete();
            end
        end
    endtask

    task automatic compare_all();
        chk("rd_data",    int'(rd_data),    cq.size() > 0 ? int'(cq[0]) : 0);
        chk("buf_empty",  int'(buf_empty),  int'(cq.size() == 0));
        chk("buf_full",   int'(buf_full),   int'((cq.size() + pk.size()) == DEPTH));
        chk("byte_count", int'(byte_count), cq.size());
        chk("pkt_ready",  int'(pkt_ready),  int'(m_ready));
        chk("pkt_len",    int'(pkt_len),    m_pkt_len);
        chk("pkt_drop",   int'(pkt_drop),   int'(m_drop));
        chk("rx_pid",     int'(rx_pid),     m_rx_pid);
        if (pkt_drop) drop_seen++;
    endtask

    // One clock: model follows the sampled inputs, outputs compared mid-cycle.
    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        compare_all();
    endtask

    task automatic wr_byte(input logic [7:0] d, input logic rd);
        rcving = 1'b1; w_enable = 1'b1; rcv_data = d; r_error = 1'b0; rd_en = rd;
        tick();
        w_enable = 1'b0; rd_en = 1'b0;
    endtask

    task automatic wr_bytes(input int n, input int base, input logic rd);
        for (int i = 0; i < n; i++) wr_byte(8'((base + i) & 255), rd);
    endtask

    task automatic fall();
        rcving = 1'b0; w_enable = 1'b0; r_error = 1'b0; rd_en = 1'b0;
        tick();
    endtask

    task automatic pop(input int exp);
        chk("pop_data", int'(rd_data), exp);
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
    endtask

    initial begin
        // Reset
        rst = 1'b1;
        tick(); tick();
        chk("rst_empty", int'(buf_empty), 1);
        chk("rst_count", int'(byte_count), 0);
        chk("rst_rd_data", int'(rd_data), 0);
        rst = 1'b0;
        tick();

        // Basic good packet C3 11 22
        wr_byte(8'hC3, 1'b0);
        wr_byte(8'h11, 1'b0);
        wr_byte(8'h22, 1'b0);
        fall();
        chk("t1_ready", int'(pkt_ready), 1);
        if (STRIP) begin
            chk("t1_len", int'(pkt_len), 2);
            chk("t1_count", int'(byte_count), 2);
            chk("t1_pid", int'(rx_pid), 8'hC3);
            tick();
            chk("t1_ready_clr", int'(pkt_ready), 0);
            pop(8'h11); pop(8'h22);
        end else begin
            chk("t1_len", int'(pkt_len), 3);
            chk("t1_count", int'(byte_count), 3);
            chk("t1_pid", int'(rx_pid), 0);
            tick();
            chk("t1_ready_clr", int'(pkt_ready), 0);
            pop(8'hC3); pop(8'h11); pop(8'h22);
        end
        chk("t1_empty", int'(buf_empty), 1);
        pop(0);                                   // pop on empty is ignored

        // Error packet: 5 bytes, r_error, then rcving falls
        wr_bytes(5, 8'h40, 1'b0);
        rcving = 1'b1; r_error = 1'b1;
        tick();
        r_error = 1'b0;
        tick();
        fall();
        chk("t3_drop", int'(pkt_drop), 1);
        chk("t3_count", int'(byte_count), 0);
        tick();
        chk("t3_drop_clr", int'(pkt_drop), 0);

        // Overflow: 60 committed, then a 10-byte packet
        wr_bytes(60 + int'(STRIP), 8'h80, 1'b0);
        fall();
        chk("t4_count60", int'(byte_count), 60);
        wr_bytes(10, 8'h10, 1'b0);
        chk("t4_full", int'(buf_full), 1);
        fall();
        chk("t4_drop", int'(pkt_drop), 1);
        chk("t4_not_full", int'(buf_full), 0);
        chk("t4_count_kept", int'(byte_count), 60);
        for (int i = 0; i < 60; i++) pop((8'h80 + int'(STRIP) + i) & 255);
        chk("t4_empty", int'(buf_empty), 1);

        // Pointer wrap: 50-byte packets, each popped while the next arrives
        for (int k = 0; k < 5; k++) begin
            wr_bytes(50 + int'(STRIP), k * 50, k > 0);
            fall();
            chk("wrap_len", int'(pkt_len), 50);
            chk("wrap_count", int'(byte_count), 50);
        end
        for (int i = 0; i < 50; i++) pop((200 + int'(STRIP) + i) & 255);
        chk("wrap_empty", int'(buf_empty), 1);

        // Reset mid-packet, then a 1-byte good packet
        drop_seen = 0;
        wr_bytes(3, 8'hA0, 1'b0);
        rcving = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        chk("rst_mid_count", int'(byte_count), 0);
        if (STRIP) wr_byte(8'h5A, 1'b0);
        wr_byte(8'h77, 1'b0);
        fall();
        chk("t6_count", int'(byte_count), 1);
        chk("t6_data", int'(rd_data), 8'h77);
        tick(); tick();
        chk("t6_no_drop", drop_seen, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/usb_rx_packet_buffer.md
# usb_rx_packet_buffer

- Receive-side packet buffer directly downstream of the USB RX control unit.
- Stores data bytes written by the control unit (`w_enable`/`rcv_data`) into a circular buffer, speculatively.
- Commits a packet to the read side only when reception ends (`rcving` falls) without an error.
- Packets with an error or an overflow are rewound, so the AHB-side reader never sees partial or corrupt packets.

## Interface

- `DEPTH`, 64: buffer size in bytes; power of two, at least 4. `AW = $clog2(DEPTH)`.
- `clk` input 1: system clock; all state updates on rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `rcving` input 1: packet in progress, from RX control unit.
- `w_enable` input 1: one-cycle byte-valid strobe from RX control unit.
- `rcv_data` input 8: received byte, valid when `w_enable`=1.
- `r_error` input 1: receive error from RX control unit.
- `rd_en` input 1: pop one committed byte.
- `rd_data` output 8: committed byte at head (first-word-fall-through); 8'h00 when empty.
- `buf_empty` output 1: no committed bytes.
- `buf_full` output 1: speculative occupancy == `DEPTH`.
- `byte_count` output AW+1: committed bytes available to the reader.
- `pkt_ready` output 1: one-cycle pulse, good packet committed.
- `pkt_len` output AW+1: data-byte length of the last committed packet; holds until the next commit.
- `pkt_drop` output 1: one-cycle pulse, packet discarded.
- `rx_pid` output 8: PID of the last committed packet (see Configuration).

## Operation

- Pointers:
  - `wr_ptr`, `cmt_ptr`, `rd_ptr` are AW+1 bits with a wrap bit.
  - Memory index is `ptr[AW-1:0]`.
  - `buf_full` = (`wr_ptr`-`rd_ptr`) == `DEPTH`.
  - `byte_count` = `cmt_ptr`-`rd_ptr`.
  - `buf_empty` = (`byte_count` == 0).
- FSM states:
  - IDLE: `rcving`=1 → ACTIVE; clear `len_cnt`.
  - ACTIVE: sampled in this priority order:
    - `r_error`=1 → BAD.
    - Write attempt while `buf_full` → BAD; byte dropped.
    - `rcving`=0 → IDLE:
      - `len_cnt`>0: `cmt_ptr`←`wr_ptr`, `pkt_len`←`len_cnt`, pulse `pkt_ready`.
      - `len_cnt`=0: silent; no pulse.
  - BAD: writes ignored. `rcving`=0 → IDLE, `wr_ptr`←`cmt_ptr`, pulse `pkt_drop`.
- Write accepted iff all hold: state ACTIVE, or IDLE with `rcving`=1; `w_enable`=1; no error this cycle; not `buf_full`.
- On an accepted write: `mem[wr_ptr]`←`rcv_data`, `wr_ptr`+1, `len_cnt`+1.
- `w_enable` or `r_error` while `rcving`=0 in IDLE: ignored.
- Read: `rd_en`=1 and not `buf_empty` → `rd_ptr`+1. `rd_en` on empty: ignored, no error.
- Simultaneous read and write: both take effect. `buf_full` is evaluated from pre-edge pointers, so a write while full is an overflow even with a concurrent pop.
- Reset mid-packet: all pointers, state and outputs cleared; the partial packet is lost with no `pkt_drop`.

## Timing

- Reset values: `rd_data`=8'h00, `buf_empty`=1, `buf_full`=0, `byte_count`=0, `pkt_ready`=0, `pkt_len`=0, `pkt_drop`=0, `rx_pid`=8'h00.
- Write latency: byte is in memory after the `w_enable` edge. It is not reader-visible until commit.
- Commit latency: on the first edge with `rcving`=0 sampled in ACTIVE, `pkt_ready`, the new `byte_count` and `pkt_len` all become valid together in the following cycle.
- Drop latency: `pkt_drop` asserts in the cycle after the first edge with `rcving`=0 sampled in BAD. `buf_full` drops in that same cycle.
- `rd_data` changes the cycle after a pop; combinational from `rd_ptr`.
- Pulses (`pkt_ready`, `pkt_drop`) are exactly one cycle and never coincide.

## Configuration

- `USB_RX_PID_STRIP_EN` defined:
  - The first accepted byte of each packet goes to a pending PID register, not memory, and is not counted in `len_cnt`.
  - A packet holding only a PID commits with `pkt_len`=0 and still pulses `pkt_ready`.
  - `rx_pid`←pending on commit. A dropped packet leaves `rx_pid` unchanged.
- Not defined:
  - All accepted bytes, including the PID, are stored and counted.
  - `rx_pid` is constant 8'h00.

## Test plan

- Packet of 8'hC3, 8'h11, 8'h22, then `rcving` falls, no macro → `pkt_ready` pulse, `pkt_len`=3, `byte_count`=3; pops return C3, 11, 22, then `buf_empty`=1.
- Same packet with `USB_RX_PID_STRIP_EN` → `rx_pid`=8'hC3, `pkt_len`=2; pops return 11, 22.
- 5 bytes, then `r_error`=1, then `rcving` falls → `pkt_drop` pulse; `byte_count` and `wr_ptr` are unchanged from before the packet.
- `DEPTH`=64 with 60 committed bytes, then a 10-byte packet → BAD after 4 stored bytes, `buf_full`=1; on the `rcving` fall, `pkt_drop` and `buf_full`=0.
- Pointer wrap: commit and pop 50-byte packets 5 times → data matches every time, wrap bit toggles, `buf_empty`/`buf_full` are correct at each wrap.
- Assert `rst` mid-packet after 3 bytes, release, then send a 1-byte good packet → `byte_count`=1, `pkt_drop` never pulses.
